// File: rtl/mul4_fitness_scorer_if.sv
// Batch and result signals between the tournament/evaluator side and the mul4 fitness scorer.
// Transfer rule: a batch moves when in_valid && in_ready at a rising clk edge; upstream holds data until then.
interface mul4_fitness_scorer_if #(
   parameter int LANES   = 16,
   parameter int SCORE_W = 9
);
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [LANES-1:0]   a1;
   logic [LANES-1:0]   a0;
   logic [LANES-1:0]   b1;
   logic [LANES-1:0]   b0;
   logic [LANES-1:0]   y3;
   logic [LANES-1:0]   y2;
   logic [LANES-1:0]   y1;
   logic [LANES-1:0]   y0;
   logic               busy;
   logic               done;
   logic [SCORE_W-1:0] score;
   logic               perfect;

   modport master (
      output start, in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
      input  in_ready, busy, done, score, perfect
   );

   modport slave (
      input  start, in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
      output in_ready, busy, done, score, perfect
   );
endinterface

// File: rtl/mul4_fitness_scorer.sv
// Scores an evolved 2x2-bit multiplier: compares candidate outputs against the golden product
// per lane and accumulates correct bits over NBATCH batches. state_dbg: 0 idle, 1 run, 2 drain, 3 done.
module mul4_fitness_scorer #(
   parameter int LANES   = 16,
   parameter int NBATCH  = 4,
   parameter int SCORE_W = $clog2(4*LANES*NBATCH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   mul4_fitness_scorer_if.slave  bus,
   output logic [1:0]            state_dbg
);
   localparam int MATCH_W   = 4*LANES;
   localparam int POP_W     = $clog2(MATCH_W+1);
   localparam int CNT_W     = (NBATCH > 1) ? $clog2(NBATCH) : 1;
   localparam int MAX_SCORE = 4*LANES*NBATCH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 transfer;
   logic                 last_transfer;
   logic                 clear;
   logic [CNT_W-1:0]     count;
   logic                 s1_valid;
   logic [MATCH_W-1:0]   s1_match;
   logic [POP_W-1:0]     s1_pop;
   logic [SCORE_W-1:0]   score;
   logic [LANES-1:0]     g0;
   logic [LANES-1:0]     g1;
   logic [LANES-1:0]     g2;
   logic [LANES-1:0]     g3;

   function automatic logic [POP_W-1:0] popcount(input logic [MATCH_W-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < MATCH_W; i++) begin
         c = c + POP_W'(v[i]);
      end
      return c;
   endfunction

   // Golden 2x2 product bits, evaluated lane-parallel.
   assign g0 = bus.a0 & bus.b0;
   assign g1 = (bus.a1 & bus.b0) ^ (bus.a0 & bus.b1);
   assign g2 = bus.a1 & bus.b1 & ~(bus.a0 & bus.b0);
   assign g3 = bus.a1 & bus.a0 & bus.b1 & bus.b0;

   // Derived from state directly so the handshake does not loop through the FSM's comb block.
   assign transfer      = bus.in_valid && (state == RUN);
   assign last_transfer = transfer && (count == CNT_W'(NBATCH-1));
   assign s1_pop        = popcount(s1_match);
   assign state_dbg     = state;
   assign bus.score     = score;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clear        = 1'b0;
      bus.in_ready = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.perfect  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         RUN: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
            if (last_transfer) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            bus.busy = 1'b1;
            // The accumulate stage is the score register itself, so an empty S1 means the sum is final.
            if (!s1_valid) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.done    = 1'b1;
            bus.perfect = (score == SCORE_W'(MAX_SCORE));
            if (bus.start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         s1_valid <= 1'b0;
         s1_match <= '0;
         score    <= '0;
      end else begin
         s1_valid <= transfer;
         // Match vector is captured only on a transfer, so idle bus contents never reach the score.
         if (transfer) begin
            s1_match <= ~({bus.y3, bus.y2, bus.y1, bus.y0} ^ {g3, g2, g1, g0});
            count    <= count + CNT_W'(1);
         end
         if (clear) begin
            count <= '0;
            score <= '0;
         end else if (s1_valid) begin
            score <= score + SCORE_W'(s1_pop);
         end
      end
   end
endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Self-checking bench for mul4_fitness_scorer: random batches scored by an arithmetic reference model.
module tb_mul4_fitness_scorer;
   localparam int LANES     = 16;
   localparam int NBATCH    = 4;
   localparam int SCORE_W   = 9;
   localparam int MAX_SCORE = 4*LANES*NBATCH;

   typedef struct {
      logic [LANES-1:0] a1, a0, b1, b0, y3, y2, y1, y0;
   } batch_t;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] state_dbg;
   int errors = 0;
   int checks = 0;
   logic [SCORE_W-1:0] exp_q[$];

   mul4_fitness_scorer_if #(.LANES(LANES), .SCORE_W(SCORE_W)) bus();

   mul4_fitness_scorer #(.LANES(LANES), .NBATCH(NBATCH), .SCORE_W(SCORE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int ref_correct(input batch_t b);
      int n = 0;
      for (int i = 0; i < LANES; i++) begin
         int a = 2*int'(b.a1[i]) + int'(b.a0[i]);
         int m = 2*int'(b.b1[i]) + int'(b.b0[i]);
         int p = a * m;
         int y = 8*int'(b.y3[i]) + 4*int'(b.y2[i]) + 2*int'(b.y1[i]) + int'(b.y0[i]);
         for (int k = 0; k < 4; k++) begin
            if (((p >> k) & 1) == ((y >> k) & 1)) n++;
         end
      end
      return n;
   endfunction

   function automatic batch_t rand_batch(input bit golden);
      batch_t b;
      b.a1 = LANES'($urandom); b.a0 = LANES'($urandom);
      b.b1 = LANES'($urandom); b.b0 = LANES'($urandom);
      b.y3 = LANES'($urandom); b.y2 = LANES'($urandom);
      b.y1 = LANES'($urandom); b.y0 = LANES'($urandom);
      if (golden) begin
         for (int i = 0; i < LANES; i++) begin
            int p = (2*int'(b.a1[i]) + int'(b.a0[i])) * (2*int'(b.b1[i]) + int'(b.b0[i]));
            b.y0[i] = p[0]; b.y1[i] = p[1]; b.y2[i] = p[2]; b.y3[i] = p[3];
         end
      end
      return b;
   endfunction

   function automatic int drain_expected();
      int s = 0;
      while (exp_q.size() > 0) s += int'(exp_q.pop_front());
      return s;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_idle();
      bus.in_valid = 1'b0;
      bus.a1 = LANES'($urandom); bus.a0 = LANES'($urandom);
      bus.b1 = LANES'($urandom); bus.b0 = LANES'($urandom);
      bus.y3 = LANES'($urandom); bus.y2 = LANES'($urandom);
      bus.y1 = LANES'($urandom); bus.y0 = LANES'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      drive_idle();
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_batch(input batch_t b);
      int waited = 0;
      bus.a1 = b.a1; bus.a0 = b.a0; bus.b1 = b.b1; bus.b0 = b.b0;
      bus.y3 = b.y3; bus.y2 = b.y2; bus.y1 = b.y1; bus.y0 = b.y0;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_timeout: in_ready=%b required 1", bus.in_ready);
      end else begin
         exp_q.push_back(SCORE_W'(ref_correct(b)));
         @(negedge clk);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
      checks++; if (bus.perfect !== 1'b0) begin errors++; $display("FAIL reset_perfect: got %b required 0", bus.perfect); end
      checks++; if (bus.score !== '0) begin errors++; $display("FAIL reset_score: got %0d required 0", bus.score); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0 (idle)", state_dbg); end
      idle_cycles(2);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_no_start_done: got %b required 0", bus.done); end
   endtask

   task automatic test_golden();
      int lat, exp;
      logic [SCORE_W-1:0] held;
      pulse_start();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL golden_busy: got %b required 1", bus.busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL golden_in_ready: got %b required 1", bus.in_ready); end
      for (int i = 0; i < NBATCH; i++) send_batch(rand_batch(1'b1));
      drive_idle();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL golden_ready_drop: got %b required 0", bus.in_ready); end
      wait_done(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL golden_latency: got %0d cycles required 3", lat); end
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL golden_score: got %0d required %0d", bus.score, exp); end
      checks++; if (bus.perfect !== 1'b1) begin errors++; $display("FAIL golden_perfect: got %b required 1", bus.perfect); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL golden_busy_done: got %b required 0", bus.busy); end
      checks++; if (state_dbg !== 2'd3) begin errors++; $display("FAIL golden_state: got %0d required 3 (done)", state_dbg); end
      held = SCORE_W'(exp);
      idle_cycles(3);
      checks++; if (bus.done !== 1'b1 || bus.score !== held) begin
         errors++; $display("FAIL done_hold: done=%b score=%0d required done=1 score=%0d", bus.done, bus.score, held);
      end
   endtask

   task automatic test_all_ones();
      int lat, exp;
      batch_t b;
      pulse_start();
      checks++; if (bus.score !== '0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL restart_clear: score=%0d done=%b required 0 0", bus.score, bus.done);
      end
      b.a1 = '1; b.a0 = '1; b.b1 = '1; b.b0 = '1;
      b.y3 = '0; b.y2 = '0; b.y1 = '0; b.y0 = '0;
      for (int i = 0; i < NBATCH; i++) send_batch(b);
      drive_idle();
      wait_done(lat);
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL all_ones_score: got %0d required %0d", bus.score, exp); end
      checks++; if (bus.perfect !== 1'b0) begin errors++; $display("FAIL all_ones_perfect: got %b required 0", bus.perfect); end
   endtask

   task automatic test_lane_flip();
      int lat, exp;
      batch_t b;
      pulse_start();
      b = rand_batch(1'b1);
      b.y0 = b.y0 ^ LANES'(16'h000F);
      send_batch(b);
      for (int i = 1; i < NBATCH; i++) send_batch(rand_batch(1'b1));
      drive_idle();
      wait_done(lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL flip_latency: got %0d cycles required 3", lat); end
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL flip_score: got %0d required %0d", bus.score, exp); end
      checks++; if (bus.perfect !== 1'b0) begin errors++; $display("FAIL flip_perfect: got %b required 0", bus.perfect); end
   endtask

   task automatic test_valid_gaps();
      int lat, exp;
      pulse_start();
      for (int i = 0; i < NBATCH; i++) begin
         if (i > 0) idle_cycles(2);
         send_batch(rand_batch(1'b0));
      end
      // extra valid batches after the last transfer must be refused
      bus.in_valid = 1'b1;
      bus.y0 = LANES'($urandom);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL gaps_ready_after_last: got %b required 0", bus.in_ready); end
      wait_done(lat);
      bus.in_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL gaps_done_timeout: done=%b required 1", bus.done); end
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL gaps_score: got %0d required %0d", bus.score, exp); end
      checks++; if (bus.perfect !== 1'b0 && exp != MAX_SCORE) begin errors++; $display("FAIL gaps_perfect: got %b required 0", bus.perfect); end
   endtask

   task automatic test_start_ignored();
      int lat, exp;
      pulse_start();
      send_batch(rand_batch(1'b1));
      send_batch(rand_batch(1'b1));
      bus.start = 1'b1;
      send_batch(rand_batch(1'b1));
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL start_run_ignored: busy=%b in_ready=%b required 1 1", bus.busy, bus.in_ready);
      end
      send_batch(rand_batch(1'b1));
      bus.start = 1'b1;
      drive_idle();
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
      checks++; if (lat + 1 !== 3) begin errors++; $display("FAIL start_latency: got %0d cycles required 3", lat + 1); end
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL start_score: got %0d required %0d", bus.score, exp); end
      checks++; if (bus.perfect !== 1'b1) begin errors++; $display("FAIL start_perfect: got %b required 1", bus.perfect); end
   endtask

   task automatic test_async_reset();
      int lat, exp;
      pulse_start();
      send_batch(rand_batch(1'b1));
      send_batch(rand_batch(1'b1));
      drive_idle();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL async_reset_ctrl: busy=%b in_ready=%b done=%b required 0 0 0", bus.busy, bus.in_ready, bus.done);
      end
      checks++; if (bus.score !== '0) begin errors++; $display("FAIL async_reset_score: got %0d required 0", bus.score); end
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      idle_cycles(2);
      checks++; if (bus.busy !== 1'b0 || bus.score !== '0) begin
         errors++; $display("FAIL post_reset_idle: busy=%b score=%0d required 0 0", bus.busy, bus.score);
      end
      pulse_start();
      for (int i = 0; i < NBATCH; i++) send_batch(rand_batch(1'b0));
      drive_idle();
      wait_done(lat);
      exp = drain_expected();
      checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL fresh_score: got %0d required %0d", bus.score, exp); end
   endtask

   task automatic test_random();
      int lat, exp;
      for (int e = 0; e < 8; e++) begin
         pulse_start();
         for (int i = 0; i < NBATCH; i++) begin
            idle_cycles($urandom_range(0, 2));
            send_batch(rand_batch(1'($urandom_range(0, 1))));
         end
         drive_idle();
         wait_done(lat);
         exp = drain_expected();
         checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rand_done[%0d]: got %b required 1", e, bus.done); end
         checks++; if (bus.score !== SCORE_W'(exp)) begin errors++; $display("FAIL rand_score[%0d]: got %0d required %0d", e, bus.score, exp); end
         checks++; if (bus.perfect !== (exp == MAX_SCORE)) begin
            errors++; $display("FAIL rand_perfect[%0d]: got %b required %b", e, bus.perfect, (exp == MAX_SCORE));
         end
         idle_cycles($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_all_ones();
      test_lane_flip();
      test_valid_gaps();
      test_start_ignored();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
